div4_seq: RTL and testbench

DIV4_SEQ -- requirements
Module: div4_seq

---
 rtl/div4_seq_if.sv | 38 +++
 rtl/div4_seq.sv | 144 ++++++++++++++
 tb/tb_div4_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/div4_seq_if.sv
// ============================================================================
// Module      : div4_seq_if
// Description : Request/result bundle for the div4_seq sequential divider.
//               master = requester side, slave = divider side.
//   start : request a division (sampled on rising clk)
//   a, b  : unsigned dividend / divisor, sampled with start
//   q, r  : unsigned quotient / remainder, valid while done is high
//   busy  : operation in progress
//   done  : one-cycle completion pulse
//   dz    : divide-by-zero flag of the completed operation
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div4_seq_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, a, b,
    input  q, r, busy, done, dz
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, dz
  );
endinterface

`default_nettype wire

// File: rtl/div4_seq.sv
// ============================================================================
// Module      : div4_seq
// Description : Unsigned restoring shift-subtract divider, one quotient bit
//               per clock. Three-state FSM: IDLE -> RUN (WIDTH cycles) ->
//               DONE (one cycle) -> IDLE. A zero divisor bypasses RUN and
//               reports q = all ones, r = a, dz = 1.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : div4_seq_if.slave (start, a, b in; q, r, busy, done, dz out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div4_seq #(
  parameter int WIDTH = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  div4_seq_if.slave   bus
);

  localparam int            C_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam [C_CNT_W-1:0]  C_LAST  = C_CNT_W'(WIDTH - 1);

  localparam [1:0] C_IDLE = 2'd0;
  localparam [1:0] C_RUN  = 2'd1;
  localparam [1:0] C_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [WIDTH-1:0]   r_dvd;        // dividend, consumed MSB first
  logic [WIDTH-1:0]   r_dvs;        // captured divisor
  logic [WIDTH:0]     r_rem;        // WIDTH+1-bit partial remainder
  logic [WIDTH-1:0]   r_q;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_dz;
  logic               r_zero_pend;  // divide-by-zero accepted, DONE next edge
  logic               w_accept;
  logic               w_zero_req;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_trial;
  logic [WIDTH-1:0]   w_q_next;
  logic               w_busy;
  logic               w_done;

  assign w_accept   = (r_state == C_IDLE) && !r_zero_pend && bus.start && (bus.b != '0);
  assign w_zero_req = (r_state == C_IDLE) && !r_zero_pend && bus.start && (bus.b == '0);

  // Shifted remainder and trial subtraction; the extra top bit of w_trial
  // is the borrow, i.e. the "negative" indication of the restoring step.
  assign w_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_trial = {r_rem, r_dvd[WIDTH-1]} - {2'b00, r_dvs};

  generate
    if (WIDTH > 1) begin : g_q_wide
      assign w_q_next = {r_q[WIDTH-2:0], ~w_trial[WIDTH+1]};
    end else begin : g_q_narrow
      assign w_q_next = ~w_trial[WIDTH+1];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A zero divisor waits one cycle in IDLE (r_zero_pend)
  // so its done pulse lands in the cycle after edge N+1.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_IDLE: begin
        if (r_zero_pend) begin
          w_state_next = C_DONE;
        end else if (w_accept) begin
          w_state_next = C_RUN;
        end
      end
      C_RUN: begin
        if (r_cnt == C_LAST) begin
          w_state_next = C_DONE;
        end
      end
      C_DONE:  w_state_next = C_IDLE;
      default: w_state_next = C_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      C_RUN:   w_busy = 1'b1;
      C_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_dz        <= 1'b0;
      r_zero_pend <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= bus.a;
      r_dvs <= bus.b;
      r_rem <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_dz  <= 1'b0;
    end else if (w_zero_req) begin
      r_zero_pend <= 1'b1;
      r_q         <= '1;
      r_rem       <= {1'b0, bus.a};
      r_dz        <= 1'b1;
    end else if (r_state == C_RUN) begin
      r_rem <= w_trial[WIDTH+1] ? w_shift : w_trial[WIDTH:0];
      r_q   <= w_q_next;
      r_dvd <= r_dvd << 1;
      r_cnt <= r_cnt + C_CNT_W'(1);
    end else begin
      r_zero_pend <= 1'b0;
    end
  end

  assign bus.q    = r_q;
  assign bus.r    = r_rem[WIDTH-1:0];
  assign bus.dz   = r_dz;
  assign bus.busy = w_busy;
  assign bus.done = w_done;

endmodule

`default_nettype wire

// File: tb/tb_div4_seq.sv
// ============================================================================
// Module      : tb_div4_seq
// Description : Self-checking bench for div4_seq (WIDTH = 4): vector table,
//               start-ignored and mid-run reset sequences, random operations
//               and a full 256-pair sweep against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div4_seq;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div4_seq_if #(.WIDTH(W)) bus ();

  div4_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  bit ab_seen;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer division, zero divisor gives all ones / a.
  task automatic ref_div(input int a, input int b, output logic [W-1:0] q,
                         output logic [W-1:0] r, output logic dz);
    if (b == 0) begin
      q  = W'((1 << W) - 1);
      r  = W'(a);
      dz = 1'b1;
    end else begin
      q  = W'(a / b);
      r  = W'(a % b);
      dz = 1'b0;
    end
  endtask

  // One operation with latency/busy profile, result and hold checks.
  // poke=1 pulses start with a=1,b=1 during the second RUN cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input string nm, input bit poke);
    int idx;
    bit seen;
    bit busy_ok;
    int exp_idx;
    exp_idx = (tbv == 0) ? 1 : W;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tbv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    idx     = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && idx < 20) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy !== ((tbv != 0) && (idx < W))) busy_ok = 1'b0;
        if (poke && idx == 1) begin
          bus.start = 1'b1;
          bus.a     = 1;
          bus.b     = 1;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        idx++;
      end
    end
    bus.start = 1'b0;
    if (seen && bus.busy !== 1'b0) busy_ok = 1'b0;
    chk({nm, "_busy_profile"}, int'(busy_ok), 1);
    chk({nm, "_done_latency"}, seen ? idx : -1, exp_idx);
    chk({nm, "_q"}, int'(bus.q), int'(eq));
    chk({nm, "_r"}, int'(bus.r), int'(er));
    chk({nm, "_dz"}, int'(bus.dz), int'(edz));
    @(negedge clk);
    chk({nm, "_hold"}, int'({bus.done, bus.q, bus.r, bus.dz}),
        int'({1'b0, eq, er, edz}));
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         mdz;

    vt[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
    vt[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
    vt[2] = '{4'd5,  4'd7,  4'd0,  4'd5, 1'b0};
    vt[3] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1};
    vt[4] = '{4'd6,  4'd2,  4'd3,  4'd0, 1'b0};
    vt[5] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
    vt[6] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
    vt[7] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1};
    vt[8] = '{4'd8,  4'd3,  4'd2,  4'd2, 1'b0};
    vt[9] = '{4'd15, 4'd2,  4'd7,  4'd1, 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_q",    int'(bus.q),    0);
    chk("rst_r",    int'(bus.r),    0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_dz",   int'(bus.dz),   0);
    rst = 1'b0;

    // Vector table, back to back
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz,
             $sformatf("vec%0d", i), 1'b0);
    end

    // start during RUN is ignored
    run_op(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, "ignore_start", 1'b1);

    // Asynchronous reset two cycles into RUN
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd14;
    bus.b     = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_busy", int'(bus.busy), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", int'({bus.q, bus.r, bus.busy, bus.done, bus.dz}), 0);
    ab_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.busy) ab_seen = 1'b1;
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.busy) ab_seen = 1'b1;
    end
    chk("abort_no_done", int'(ab_seen), 0);
    run_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, "after_abort", 1'b0);

    // Random operations, some with a forced zero divisor
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = (i % 8 == 0) ? '0 : W'($urandom);
      ref_div(int'(ra), int'(rb), mq, mr, mdz);
      run_op(ra, rb, mq, mr, mdz, $sformatf("rnd%0d_%0d_%0d", i, ra, rb), 1'b0);
    end

    // Full sweep
    for (int ia = 0; ia < (1 << W); ia++) begin
      for (int ib = 0; ib < (1 << W); ib++) begin
        ref_div(ia, ib, mq, mr, mdz);
        run_op(W'(ia), W'(ib), mq, mr, mdz, $sformatf("sweep_%0d_%0d", ia, ib), 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
